// File: rtl/man_decoder_thomas.sv
// man_decoder_thomas: G.E. Thomas Manchester receiver recovering NRZ bits from an oversampled line
module man_decoder_thomas #(
   parameter int SAMPLES_PER_BIT = 6,
   parameter int CNT_W = $clog2(2*SAMPLES_PER_BIT+1)
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic bit_out,
   output logic bit_valid,
   output logic locked,
   output logic code_err,
   output logic frame_end
);
   localparam int N = SAMPLES_PER_BIT;
   localparam logic [CNT_W-1:0] S_LO  = CNT_W'(N/4);
   localparam logic [CNT_W-1:0] L_LO  = CNT_W'(3*N/4);
   localparam logic [CNT_W-1:0] L_HI  = CNT_W'(5*N/4);
   localparam logic [CNT_W-1:0] C_SAT = CNT_W'(2*N);
   typedef enum logic {HUNT, LOCK} state_t;
   state_t state, state_nx;
   logic s1, s2, s3, bnd_seen, bnd_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic edg, in_short, in_long, err, timeout;
   logic bv_nx, ce_nx, fe_nx;
   assign edg      = s2 ^ s3;
   assign in_long  = (cnt >= L_LO) && (cnt <= L_HI);
   assign in_short = (cnt >= S_LO) && (cnt < L_LO);
   // in LOCK every edge that is neither a mid edge nor the first boundary edge is a violation
   assign err      = edg && !in_long && !(in_short && !bnd_seen);
   assign timeout  = !edg && (cnt == L_HI);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         state     <= HUNT;
         cnt       <= '0;
         bnd_seen  <= 1'b0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         locked    <= 1'b0;
         code_err  <= 1'b0;
         frame_end <= 1'b0;
      end else begin
         s1        <= line_in;
         s2        <= s1;
         s3        <= s2;
         state     <= state_nx;
         cnt       <= cnt_nx;
         bnd_seen  <= bnd_nx;
         bit_out   <= bv_nx ? ~s2 : bit_out;
         bit_valid <= bv_nx;
         locked    <= (state_nx == LOCK);
         code_err  <= ce_nx;
         frame_end <= fe_nx;
      end
   end
   always_comb begin
      state_nx = state;
      cnt_nx   = (cnt == C_SAT) ? cnt : cnt + 1'b1;
      bnd_nx   = bnd_seen;
      if (state == HUNT) begin
         if (edg) cnt_nx = '0;
         if (edg && in_long) begin
            state_nx = LOCK;
            bnd_nx   = 1'b0;
         end
      end else if (edg && in_long) begin
         cnt_nx = '0;
         bnd_nx = 1'b0;
      end else if (err || timeout) begin
         state_nx = HUNT;
         cnt_nx   = '0;
         bnd_nx   = 1'b0;
      end else if (edg) begin
         bnd_nx = 1'b1;
      end
   end
   always_comb begin
      bv_nx = edg && in_long;
      ce_nx = (state == LOCK) && err;
      fe_nx = (state == LOCK) && timeout;
   end
endmodule

// File: tb/tb_man_decoder_thomas.sv
// tb_man_decoder_thomas: directed checks of the Manchester receiver with N=6
module tb_man_decoder_thomas;
   logic clk, reset, line_in;
   logic bit_out, bit_valid, locked, code_err, frame_end;
   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   bit q_bits[$];
   int q_bcyc[$];
   int q_mid[$];
   int ce_n, ce_cyc, fe_n, fe_cyc, clash;

   man_decoder_thomas #(.SAMPLES_PER_BIT(6)) dut (
      .clk(clk), .reset(reset), .line_in(line_in), .bit_out(bit_out),
      .bit_valid(bit_valid), .locked(locked), .code_err(code_err), .frame_end(frame_end)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // record every output pulse with the cycle it became visible
   always @(negedge clk) begin
      if (bit_valid) begin
         q_bits.push_back(bit_out);
         q_bcyc.push_back(cyc);
      end
      if (code_err) begin
         ce_n++;
         ce_cyc = cyc;
      end
      if (frame_end) begin
         fe_n++;
         fe_cyc = cyc;
      end
      if (bit_valid && (code_err || frame_end)) clash++;
   end

   task automatic clr();
      q_bits.delete();
      q_bcyc.delete();
      q_mid.delete();
      ce_n = 0;
      fe_n = 0;
      clash = 0;
      ce_cyc = -1;
      fe_cyc = -1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one bit: mid edge len clocks after the previous mid, boundary edge (if needed) 3 clocks after it
   task automatic seg(input bit b, input int len);
      for (int i = 1; i <= len; i++) begin
         @(negedge clk);
         if (i == len) begin
            line_in = ~b;
            q_mid.push_back(cyc);
         end else if (i == 3 && line_in != b) begin
            line_in = b;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit jit, input int nd);
      logic [11:0] pat;
      pat = {4'b0101, d};
      for (int i = 0; i < 4 + nd; i++) seg(pat[11-i], jit ? ((i % 2) ? 5 : 7) : 6);
   endtask

   function automatic logic [7:0] got_byte();
      logic [7:0] r;
      r = 'x;
      if (q_bits.size() >= 8)
         for (int j = 0; j < 8; j++) r[7-j] = q_bits[q_bits.size()-8+j];
      return r;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      line_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         line_in = ~line_in;
         n_chk++;
         if ({bit_out, bit_valid, locked, code_err, frame_end} !== 5'b0)
            $display("FAIL reset_outputs cyc %0d: got %b want 00000", i,
                     {bit_out, bit_valid, locked, code_err, frame_end});
         else n_pass++;
      end
      @(negedge clk);
      line_in = 1'b0;
      reset = 1'b0;
      idle(20);
      n_chk++;
      if ({locked, bit_valid, code_err, frame_end} !== 4'b0)
         $display("FAIL reset_release_hunt: got %b want 0000", {locked, bit_valid, code_err, frame_end});
      else n_pass++;
   endtask

   task automatic test_lock();
      logic [10:0] pat;
      pat = {3'b101, 8'hA5};
      clr();
      send_frame(8'hA5, 1'b0, 8);
      n_chk++;
      if (locked !== 1'b1) $display("FAIL lock_locked: got %b want 1", locked);
      else n_pass++;
      idle(20);
      n_chk++;
      if (q_bits.size() !== 11) $display("FAIL lock_bit_count: got %0d want 11", q_bits.size());
      else n_pass++;
      for (int j = 0; j < 11 && j < q_bits.size(); j++) begin
         n_chk++;
         if (q_bits[j] !== pat[10-j]) $display("FAIL lock_bit%0d: got %b want %b", j, q_bits[j], pat[10-j]);
         else n_pass++;
         n_chk++;
         if (q_bcyc[j] !== q_mid[j+1] + 3)
            $display("FAIL lock_latency%0d: got cyc %0d want %0d", j, q_bcyc[j], q_mid[j+1] + 3);
         else n_pass++;
      end
      n_chk++;
      if (fe_n !== 1 || fe_cyc !== q_bcyc[q_bcyc.size()-1] + 8)
         $display("FAIL frame_end: got %0d pulses at cyc %0d want 1 at %0d", fe_n, fe_cyc,
                  q_bcyc[q_bcyc.size()-1] + 8);
      else n_pass++;
      n_chk++;
      if (locked !== 1'b0 || ce_n !== 0 || clash !== 0)
         $display("FAIL frame_end_state: got locked %b code_err %0d clash %0d want 0 0 0", locked, ce_n, clash);
      else n_pass++;
   endtask

   task automatic test_glitch();
      int g;
      clr();
      send_frame(8'h3C, 1'b0, 8);
      idle(2);
      line_in = ~line_in;
      @(negedge clk);
      line_in = ~line_in;
      g = cyc;
      idle(10);
      n_chk++;
      if (q_bits.size() !== 11 || got_byte() !== 8'h3C)
         $display("FAIL glitch_pre_byte: got %0d bits %h want 11 bits 3c", q_bits.size(), got_byte());
      else n_pass++;
      n_chk++;
      if (ce_n !== 1 || ce_cyc !== g + 3)
         $display("FAIL glitch_code_err: got %0d pulses at cyc %0d want 1 at %0d", ce_n, ce_cyc, g + 3);
      else n_pass++;
      n_chk++;
      if (locked !== 1'b0 || fe_n !== 0)
         $display("FAIL glitch_unlock: got locked %b frame_end %0d want 0 0", locked, fe_n);
      else n_pass++;
      idle(10);
      clr();
      send_frame(8'h5A, 1'b0, 8);
      n_chk++;
      if (locked !== 1'b1) $display("FAIL glitch_relock: got %b want 1", locked);
      else n_pass++;
      idle(20);
      n_chk++;
      if (q_bits.size() !== 11 || got_byte() !== 8'h5A)
         $display("FAIL glitch_relock_byte: got %0d bits %h want 11 bits 5a", q_bits.size(), got_byte());
      else n_pass++;
   endtask

   task automatic test_jitter();
      logic [10:0] pat;
      pat = {3'b101, 8'hC3};
      clr();
      send_frame(8'hC3, 1'b1, 8);
      idle(20);
      n_chk++;
      if (q_bits.size() !== 11) $display("FAIL jitter_bit_count: got %0d want 11", q_bits.size());
      else n_pass++;
      for (int j = 0; j < 11 && j < q_bits.size(); j++) begin
         n_chk++;
         if (q_bits[j] !== pat[10-j] || q_bcyc[j] !== q_mid[j+1] + 3)
            $display("FAIL jitter_bit%0d: got %b at cyc %0d want %b at %0d", j, q_bits[j], q_bcyc[j],
                     pat[10-j], q_mid[j+1] + 3);
         else n_pass++;
      end
      n_chk++;
      if (ce_n !== 0 || fe_n !== 1 || clash !== 0)
         $display("FAIL jitter_flags: got code_err %0d frame_end %0d clash %0d want 0 1 0", ce_n, fe_n, clash);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      clr();
      send_frame(8'hF0, 1'b0, 4);
      idle(1);
      n_chk++;
      if (locked !== 1'b1) $display("FAIL midreset_pre_locked: got %b want 1", locked);
      else n_pass++;
      #3 reset = 1'b1;
      #1;
      n_chk++;
      if ({bit_out, bit_valid, locked, code_err, frame_end} !== 5'b0)
         $display("FAIL midreset_async: got %b want 00000", {bit_out, bit_valid, locked, code_err, frame_end});
      else n_pass++;
      idle(2);
      reset = 1'b0;
      idle(20);
      n_chk++;
      if (fe_n !== 0 || ce_n !== 0 || locked !== 1'b0)
         $display("FAIL midreset_quiet: got frame_end %0d code_err %0d locked %b want 0 0 0", fe_n, ce_n, locked);
      else n_pass++;
      clr();
      send_frame(8'h96, 1'b0, 8);
      idle(20);
      n_chk++;
      if (q_bits.size() !== 11 || got_byte() !== 8'h96)
         $display("FAIL midreset_relock: got %0d bits %h want 11 bits 96", q_bits.size(), got_byte());
      else n_pass++;
   endtask

   initial begin
      clr();
      test_reset();
      test_lock();
      test_glitch();
      test_jitter();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
